// File: rtl/net_if_pkg.sv
// Shared types and LED map for the network port control shim.
package net_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } tx_gate_state_t;

    localparam int LED_HEARTBEAT = 0;
    localparam int LED_LINK_BASE = 1;
    localparam int LED_ACT_BASE  = 2;
    localparam int LED_PORTS     = 3;

endpackage

// File: rtl/net_port_gate.sv
// One port: link debounce, frame-safe TX gate, frame counters, activity stretch.
module net_port_gate
    import net_if_pkg::*;
#(
    parameter int LINK_DEBOUNCE = 1024,
    parameter int CNT_WIDTH     = 32,
    parameter int LED_STRETCH_W = 22
) (
    input  logic                 clk156,
    input  logic                 reset,
    input  logic                 raw_link_i,
    input  logic                 cnt_clear_i,
    input  logic                 s_valid_i,
    input  logic                 s_last_i,
    output logic                 s_ready_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    input  logic                 rx_valid_i,
    input  logic                 rx_ready_i,
    input  logic                 rx_last_i,
    output logic                 link_up_o,
    output logic                 act_o,
    output logic [CNT_WIDTH-1:0] tx_pkt_cnt_o,
    output logic [CNT_WIDTH-1:0] tx_drop_cnt_o,
    output logic [CNT_WIDTH-1:0] rx_pkt_cnt_o,
    output tx_gate_state_t       state_o
);

    localparam int DB_W = $clog2(LINK_DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(LINK_DEBOUNCE);

    logic [DB_W-1:0]          db_cnt_q, db_cnt_d;
    logic                     link_q, link_d;
    tx_gate_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0]     tx_cnt_q, tx_cnt_d;
    logic [CNT_WIDTH-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0]     rx_cnt_q, rx_cnt_d;
    logic [LED_STRETCH_W-1:0] stretch_q, stretch_d;
    logic                     fwd, accept, tx_hs, rx_hs;

    // Link rises only after a full debounce window; any low sample drops it next cycle.
    always_comb begin
        db_cnt_d = db_cnt_q;
        if (!raw_link_i) begin
            db_cnt_d = '0;
        end else if (db_cnt_q != DB_MAX) begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
        link_d = raw_link_i && (db_cnt_q == DB_MAX);
    end

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Link state is only consulted at frame boundaries (IDLE).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !s_last_i) state_d = link_q ? PASS : DROP;
            PASS: if (accept && s_last_i) state_d = IDLE;
            DROP: if (accept && s_last_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fwd       = (state_q == PASS) || ((state_q == IDLE) && link_q);
        m_valid_o = !reset && fwd && s_valid_i;
        s_ready_o = !reset && (fwd ? m_ready_i : 1'b1);
        accept    = s_valid_i && s_ready_o;
        tx_hs     = m_valid_o && m_ready_i;
        rx_hs     = rx_valid_i && rx_ready_i;
    end

    always_comb begin
        tx_cnt_d   = tx_cnt_q;
        drop_cnt_d = drop_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        if (cnt_clear_i) begin
            tx_cnt_d   = '0;
            drop_cnt_d = '0;
            rx_cnt_d   = '0;
        end else begin
            if (tx_hs && s_last_i)            tx_cnt_d   = tx_cnt_q + CNT_WIDTH'(1);
            if (accept && !fwd && s_last_i)   drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            if (rx_hs && rx_last_i)           rx_cnt_d   = rx_cnt_q + CNT_WIDTH'(1);
        end
        stretch_d = stretch_q;
        if (tx_hs || rx_hs) begin
            stretch_d = '1;
        end else if (stretch_q != '0) begin
            stretch_d = stretch_q - LED_STRETCH_W'(1);
        end
    end

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            db_cnt_q   <= '0;
            link_q     <= 1'b0;
            tx_cnt_q   <= '0;
            drop_cnt_q <= '0;
            rx_cnt_q   <= '0;
            stretch_q  <= '0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            link_q     <= link_d;
            tx_cnt_q   <= tx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            stretch_q  <= stretch_d;
        end
    end

    assign link_up_o     = link_q;
    assign act_o         = (stretch_q != '0);
    assign tx_pkt_cnt_o  = tx_cnt_q;
    assign tx_drop_cnt_o = drop_cnt_q;
    assign rx_pkt_cnt_o  = rx_cnt_q;
    assign state_o       = state_q;

endmodule

// File: rtl/net_if_port_ctrl.sv
// N-port TX link gate and status shim in front of the 10G MACs; RX is snooped only.
module net_if_port_ctrl
    import net_if_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int DATA_WIDTH    = 64,
    parameter int LINK_DEBOUNCE = 1024,
    parameter int CNT_WIDTH     = 32,
    parameter int LED_STRETCH_W = 22,
    parameter int HEARTBEAT_W   = 26
) (
    input  logic                              clk156,
    input  logic                              reset,
    input  logic [8*NUM_PORTS-1:0]            core_status,
    input  logic                              cnt_clear,
    input  logic [DATA_WIDTH*NUM_PORTS-1:0]   s_tx_data,
    input  logic [DATA_WIDTH/8*NUM_PORTS-1:0] s_tx_keep,
    input  logic [NUM_PORTS-1:0]              s_tx_valid,
    input  logic [NUM_PORTS-1:0]              s_tx_last,
    output logic [NUM_PORTS-1:0]              s_tx_ready,
    output logic [DATA_WIDTH*NUM_PORTS-1:0]   m_tx_data,
    output logic [DATA_WIDTH/8*NUM_PORTS-1:0] m_tx_keep,
    output logic [NUM_PORTS-1:0]              m_tx_valid,
    output logic [NUM_PORTS-1:0]              m_tx_last,
    input  logic [NUM_PORTS-1:0]              m_tx_ready,
    input  logic [NUM_PORTS-1:0]              rx_valid,
    input  logic [NUM_PORTS-1:0]              rx_ready,
    input  logic [NUM_PORTS-1:0]              rx_last,
    output logic [NUM_PORTS-1:0]              link_up,
    output logic [CNT_WIDTH*NUM_PORTS-1:0]    tx_pkt_cnt,
    output logic [CNT_WIDTH*NUM_PORTS-1:0]    tx_drop_cnt,
    output logic [CNT_WIDTH*NUM_PORTS-1:0]    rx_pkt_cnt,
    output logic [7:0]                        led,
    output logic [2*NUM_PORTS-1:0]            dbg_gate_state
);

    logic [NUM_PORTS-1:0]   act;
    logic [LED_PORTS-1:0]   link_pad, act_pad;
    logic [HEARTBEAT_W-1:0] hb_q;
    logic [7:0]             led_q, led_d;
    logic                   unused_status;

    // Payload is never registered; only valid/ready are gated.
    assign m_tx_data = s_tx_data;
    assign m_tx_keep = s_tx_keep;
    assign m_tx_last = s_tx_last;

    assign unused_status = ^core_status;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        tx_gate_state_t gate_state;

        net_port_gate #(
            .LINK_DEBOUNCE(LINK_DEBOUNCE),
            .CNT_WIDTH    (CNT_WIDTH),
            .LED_STRETCH_W(LED_STRETCH_W)
        ) u_gate (
            .clk156       (clk156),
            .reset        (reset),
            .raw_link_i   (core_status[p*8]),
            .cnt_clear_i  (cnt_clear),
            .s_valid_i    (s_tx_valid[p]),
            .s_last_i     (s_tx_last[p]),
            .s_ready_o    (s_tx_ready[p]),
            .m_valid_o    (m_tx_valid[p]),
            .m_ready_i    (m_tx_ready[p]),
            .rx_valid_i   (rx_valid[p]),
            .rx_ready_i   (rx_ready[p]),
            .rx_last_i    (rx_last[p]),
            .link_up_o    (link_up[p]),
            .act_o        (act[p]),
            .tx_pkt_cnt_o (tx_pkt_cnt[p*CNT_WIDTH +: CNT_WIDTH]),
            .tx_drop_cnt_o(tx_drop_cnt[p*CNT_WIDTH +: CNT_WIDTH]),
            .rx_pkt_cnt_o (rx_pkt_cnt[p*CNT_WIDTH +: CNT_WIDTH]),
            .state_o      (gate_state)
        );

        assign dbg_gate_state[2*p +: 2] = gate_state;
    end

    // Only the first three ports have LEDs; absent ports read as dark.
    for (genvar l = 0; l < LED_PORTS; l++) begin : g_led_pad
        if (l < NUM_PORTS) begin : g_present
            assign link_pad[l] = link_up[l];
            assign act_pad[l]  = act[l];
        end else begin : g_absent
            assign link_pad[l] = 1'b0;
            assign act_pad[l]  = 1'b0;
        end
    end

    always_comb begin
        led_d = '0;
        led_d[LED_HEARTBEAT] = hb_q[HEARTBEAT_W-1];
        for (int l = 0; l < LED_PORTS; l++) begin
            led_d[LED_LINK_BASE + 2*l] = link_pad[l];
            led_d[LED_ACT_BASE + 2*l]  = act_pad[l];
        end
    end

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            hb_q  <= '0;
            led_q <= '0;
        end else begin
            hb_q  <= hb_q + HEARTBEAT_W'(1);
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule
